pe_lsu_ctrl: RTL and testbench

//  PE load/store control stage, directly downstream of the PE address generation unit.

---
 rtl/pe_lsu_ctrl_pkg.sv | 18 +
 rtl/pe_lsu_load_align.sv | 46 ++++
 rtl/pe_lsu_ctrl.sv | 179 +++++++++++++++++
 tb/tb_pe_lsu_ctrl.sv | 368 ++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pe_lsu_ctrl_pkg.sv
// Shared definitions for the PE load/store control stage.
//   - LSU opcode encodings and their width
//   - load/store control FSM state encoding (2 bits)
package pe_lsu_ctrl_pkg;

  localparam int LSU_OP_W = 2;

  localparam logic [LSU_OP_W-1:0] LSU_OP_WORD = 2'd0;
  localparam logic [LSU_OP_W-1:0] LSU_OP_HALF = 2'd1;
  localparam logic [LSU_OP_W-1:0] LSU_OP_BYTE = 2'd2;

  typedef enum logic [1:0] {
    PE_LSU_ST_IDLE    = 2'd0,
    PE_LSU_ST_REQ     = 2'd1,
    PE_LSU_ST_WAIT_RD = 2'd2
  } lsu_state_e;

endpackage

// File: rtl/pe_lsu_load_align.sv
// Load data alignment for the PE LSU.
// Picks the addressed half-word or byte out of the full memory word and
// zero- or sign-extends it; word loads and unknown opcodes pass through.
// Ports:
//   opcode_i   LSU opcode (WORD / HALF / BYTE)
//   offset_i   byte offset within the word (address[1:0])
//   signed_i   1 = sign-extend sub-word results
//   rdata_i    full word returned by memory
//   aligned_o  aligned, extended load result
module pe_lsu_load_align
  import pe_lsu_ctrl_pkg::*;
#(
  parameter int DATA_W = 32,
  parameter int OP_W   = LSU_OP_W
) (
  input  logic [OP_W-1:0]   opcode_i,
  input  logic [1:0]        offset_i,
  input  logic              signed_i,
  input  logic [DATA_W-1:0] rdata_i,
  output logic [DATA_W-1:0] aligned_o
);

  function automatic logic [DATA_W-1:0] ext_byte(input logic [7:0] b, input logic sgn);
    return {{(DATA_W-8){sgn & b[7]}}, b};
  endfunction

  function automatic logic [DATA_W-1:0] ext_half(input logic [15:0] h, input logic sgn);
    return {{(DATA_W-16){sgn & h[15]}}, h};
  endfunction

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel  = rdata_i[{offset_i, 3'b000} +: 8];
    // Half-word loads ignore offset[0]; the AGU keeps them half-aligned.
    half_sel  = offset_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    aligned_o = rdata_i;
    case (opcode_i)
      OP_W'(LSU_OP_HALF): aligned_o = ext_half(half_sel, signed_i);
      OP_W'(LSU_OP_BYTE): aligned_o = ext_byte(byte_sel, signed_i);
      default:            aligned_o = rdata_i;
    endcase
  end

endmodule

// File: rtl/pe_lsu_ctrl.sv
// PE load/store control stage, downstream of the address generation unit.
// Issues AGU loads/stores to the PE data memory over a req/gnt + rvalid
// handshake, stalls the PE pipeline while an access is outstanding, and
// returns aligned/extended load data with its destination register.
// Ports:
//   iClk, iReset_n            clock (rising edge), async active-low reset
//   iAGU_LSU_*                request from the AGU (we/re, be, opcode,
//                             signed, dest reg, byte address, store data)
//   oLSU_DMEM_*               memory request: req, we, be, word addr, wdata
//   iDMEM_LSU_Gnt/Rvalid/Rdata memory grant and read return
//   oLSU_Stall                hold the PE pipeline
//   oLSU_WB_Valid/Data/Dest_Reg load writeback (valid is a 1-cycle pulse)
//   oLSU_Error                sticky: rvalid seen with no read outstanding
module pe_lsu_ctrl
  import pe_lsu_ctrl_pkg::*;
#(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int REG_IDX_W = 5,
  parameter int OP_W      = LSU_OP_W
) (
  input  logic                 iClk,
  input  logic                 iReset_n,
  input  logic                 iAGU_LSU_Write_Enable,
  input  logic                 iAGU_LSU_Read_Enable,
  input  logic [3:0]           iAGU_LSU_Byte_Select,
  input  logic [OP_W-1:0]      iAGU_LSU_Opcode,
  input  logic                 iAGU_LSU_Load_Signed,
  input  logic [REG_IDX_W-1:0] iAGU_LSU_Dest_Reg,
  input  logic [ADDR_W-1:0]    iAGU_LSU_Address,
  input  logic [DATA_W-1:0]    iAGU_LSU_Store_Data,
  output logic                 oLSU_DMEM_Req,
  output logic                 oLSU_DMEM_We,
  output logic [3:0]           oLSU_DMEM_Be,
  output logic [ADDR_W-3:0]    oLSU_DMEM_Addr,
  output logic [DATA_W-1:0]    oLSU_DMEM_Wdata,
  input  logic                 iDMEM_LSU_Gnt,
  input  logic                 iDMEM_LSU_Rvalid,
  input  logic [DATA_W-1:0]    iDMEM_LSU_Rdata,
  output logic                 oLSU_Stall,
  output logic                 oLSU_WB_Valid,
  output logic [DATA_W-1:0]    oLSU_WB_Data,
  output logic [REG_IDX_W-1:0] oLSU_WB_Dest_Reg,
  output logic                 oLSU_Error
);

  lsu_state_e state_q, state_d;

  // Held request, used only in REQ / WAIT_RD.
  logic                 we_q;
  logic [3:0]           be_q;
  logic [ADDR_W-3:0]    waddr_q;
  logic [DATA_W-1:0]    wdata_q;
  logic [OP_W-1:0]      op_q;
  logic [1:0]           off_q;
  logic                 sgn_q;
  logic [REG_IDX_W-1:0] dest_q;

  logic                 wb_valid_q;
  logic [DATA_W-1:0]    wb_data_q;
  logic [REG_IDX_W-1:0] wb_dest_q;
  logic                 err_q;

  logic                 store_in;
  logic                 valid_req;
  logic                 capture_full;
  logic                 capture_load;
  logic                 rd_done;
  logic [DATA_W-1:0]    aligned;

  // A request with both enables set is a store; a store with no byte
  // enables has nothing to write and is dropped entirely.
  assign store_in  = iAGU_LSU_Write_Enable;
  assign valid_req = store_in ? (iAGU_LSU_Byte_Select != 4'h0) : iAGU_LSU_Read_Enable;

  assign capture_full = (state_q == PE_LSU_ST_IDLE) & valid_req & ~iDMEM_LSU_Gnt;
  assign capture_load = (state_q == PE_LSU_ST_IDLE) & valid_req & iDMEM_LSU_Gnt & ~store_in;
  assign rd_done      = (state_q == PE_LSU_ST_WAIT_RD) & iDMEM_LSU_Rvalid;

  // Memory-side request mux: live AGU inputs in IDLE, hold registers after.
  always_comb begin
    oLSU_DMEM_Req   = 1'b0;
    oLSU_DMEM_We    = we_q;
    oLSU_DMEM_Be    = be_q;
    oLSU_DMEM_Addr  = waddr_q;
    oLSU_DMEM_Wdata = wdata_q;
    case (state_q)
      PE_LSU_ST_IDLE: begin
        oLSU_DMEM_Req   = valid_req;
        oLSU_DMEM_We    = store_in;
        oLSU_DMEM_Be    = iAGU_LSU_Byte_Select;
        oLSU_DMEM_Addr  = iAGU_LSU_Address[ADDR_W-1:2];
        oLSU_DMEM_Wdata = iAGU_LSU_Store_Data;
      end
      PE_LSU_ST_REQ:     oLSU_DMEM_Req = 1'b1;
      PE_LSU_ST_WAIT_RD: oLSU_DMEM_Req = 1'b0;
      default:           oLSU_DMEM_Req = 1'b0;
    endcase
  end

  // Stall stays high through the rvalid cycle, giving a fixed one-bubble
  // release after a load.
  assign oLSU_Stall = (state_q != PE_LSU_ST_IDLE) | capture_full;

  always_comb begin
    state_d = state_q;
    case (state_q)
      PE_LSU_ST_IDLE: begin
        if (valid_req) begin
          if (!iDMEM_LSU_Gnt) state_d = PE_LSU_ST_REQ;
          else if (!store_in) state_d = PE_LSU_ST_WAIT_RD;
        end
      end
      PE_LSU_ST_REQ: begin
        if (iDMEM_LSU_Gnt) state_d = we_q ? PE_LSU_ST_IDLE : PE_LSU_ST_WAIT_RD;
      end
      PE_LSU_ST_WAIT_RD: begin
        if (iDMEM_LSU_Rvalid) state_d = PE_LSU_ST_IDLE;
      end
      default: state_d = PE_LSU_ST_IDLE;
    endcase
  end

  pe_lsu_load_align #(
    .DATA_W (DATA_W),
    .OP_W   (OP_W)
  ) u_align (
    .opcode_i  (op_q),
    .offset_i  (off_q),
    .signed_i  (sgn_q),
    .rdata_i   (iDMEM_LSU_Rdata),
    .aligned_o (aligned)
  );

  always_ff @(posedge iClk or negedge iReset_n) begin
    if (!iReset_n) begin
      state_q    <= PE_LSU_ST_IDLE;
      we_q       <= 1'b0;
      be_q       <= 4'h0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      op_q       <= '0;
      off_q      <= 2'b00;
      sgn_q      <= 1'b0;
      dest_q     <= '0;
      wb_valid_q <= 1'b0;
      wb_data_q  <= '0;
      wb_dest_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q <= state_d;
      if (capture_full) begin
        we_q    <= store_in;
        be_q    <= iAGU_LSU_Byte_Select;
        waddr_q <= iAGU_LSU_Address[ADDR_W-1:2];
        wdata_q <= iAGU_LSU_Store_Data;
      end
      // Load metadata is needed both for an immediate grant and a delayed one.
      if (capture_full || capture_load) begin
        op_q   <= iAGU_LSU_Opcode;
        off_q  <= iAGU_LSU_Address[1:0];
        sgn_q  <= iAGU_LSU_Load_Signed;
        dest_q <= iAGU_LSU_Dest_Reg;
      end
      wb_valid_q <= rd_done;
      if (rd_done) begin
        wb_data_q <= aligned;
        wb_dest_q <= dest_q;
      end
      if (iDMEM_LSU_Rvalid && (state_q != PE_LSU_ST_WAIT_RD)) err_q <= 1'b1;
    end
  end

  assign oLSU_WB_Valid    = wb_valid_q;
  assign oLSU_WB_Data     = wb_data_q;
  assign oLSU_WB_Dest_Reg = wb_dest_q;
  assign oLSU_Error       = err_q;

endmodule

// File: tb/tb_pe_lsu_ctrl.sv
// Self-checking bench for pe_lsu_ctrl: reset state, directed handshake
// sequences, a table of alignment vectors and randomized traffic checked
// against an arithmetic reference model.
module tb_pe_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        we, re, sgn, gnt, rvalid;
  logic [3:0]  be;
  logic [1:0]  op;
  logic [4:0]  dest;
  logic [31:0] addr, sd, rdata;
  logic        req, dwe, stall, wbv, err;
  logic [3:0]  dbe;
  logic [29:0] daddr;
  logic [31:0] dwdata, wbd;
  logic [4:0]  wbdest;

  int n_chk  = 0;
  int n_pass = 0;

  always #5 clk = ~clk;

  pe_lsu_ctrl #(
    .DATA_W (32), .ADDR_W (32), .REG_IDX_W (5), .OP_W (2)
  ) dut (
    .iClk                  (clk),
    .iReset_n              (rst_n),
    .iAGU_LSU_Write_Enable (we),
    .iAGU_LSU_Read_Enable  (re),
    .iAGU_LSU_Byte_Select  (be),
    .iAGU_LSU_Opcode       (op),
    .iAGU_LSU_Load_Signed  (sgn),
    .iAGU_LSU_Dest_Reg     (dest),
    .iAGU_LSU_Address      (addr),
    .iAGU_LSU_Store_Data   (sd),
    .oLSU_DMEM_Req         (req),
    .oLSU_DMEM_We          (dwe),
    .oLSU_DMEM_Be          (dbe),
    .oLSU_DMEM_Addr        (daddr),
    .oLSU_DMEM_Wdata       (dwdata),
    .iDMEM_LSU_Gnt         (gnt),
    .iDMEM_LSU_Rvalid      (rvalid),
    .iDMEM_LSU_Rdata       (rdata),
    .oLSU_Stall            (stall),
    .oLSU_WB_Valid         (wbv),
    .oLSU_WB_Data          (wbd),
    .oLSU_WB_Dest_Reg      (wbdest),
    .oLSU_Error            (err)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic agu_idle();
    we = 0; re = 0; be = 4'h0; op = 2'd0; sgn = 0; dest = 5'd0; addr = 32'h0; sd = 32'h0;
  endtask

  task automatic agu_req(input logic w, input logic r, input logic [3:0] b, input logic [1:0] o,
                         input logic s, input logic [4:0] d, input logic [31:0] a, input logic [31:0] data);
    we = w; re = r; be = b; op = o; sgn = s; dest = d; addr = a; sd = data;
  endtask

  // Reference alignment from the data-format rules: shift the addressed
  // lane down, mask it, and subtract 2^n for negative signed values.
  function automatic logic [31:0] ref_align(input int opc, input int off, input bit s, input logic [31:0] w);
    longint v;
    case (opc)
      1: begin
        v = longint'((w >> (16 * (off / 2))) & 32'h0000_FFFF);
        if (s && v >= 32768) v = v - 65536;
      end
      2: begin
        v = longint'((w >> (8 * off)) & 32'h0000_00FF);
        if (s && v >= 128) v = v - 256;
      end
      default: v = longint'(w);
    endcase
    return v[31:0];
  endfunction

  typedef struct {
    logic [1:0]  op;
    logic [1:0]  off;
    logic        sgn;
    logic [31:0] rdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[8];

  initial begin
    #500000;
    $display("FAIL watchdog: got 0x%08h expected 0x%08h", 1, 0);
    $fatal(1, "simulation timed out");
  end

  initial begin
    logic [31:0] last_wbd;
    logic [4:0]  last_dest;
    bit          seen;

    tbl[0] = '{2'd0, 2'd0, 1'b0, 32'h8011_2233, 32'h8011_2233};
    tbl[1] = '{2'd1, 2'd0, 1'b1, 32'h1234_8001, 32'hFFFF_8001};
    tbl[2] = '{2'd1, 2'd2, 1'b0, 32'h9ABC_0000, 32'h0000_9ABC};
    tbl[3] = '{2'd1, 2'd2, 1'b1, 32'h9ABC_0000, 32'hFFFF_9ABC};
    tbl[4] = '{2'd2, 2'd0, 1'b0, 32'h1122_33F0, 32'h0000_00F0};
    tbl[5] = '{2'd2, 2'd1, 1'b1, 32'h1122_7F00, 32'h0000_007F};
    tbl[6] = '{2'd2, 2'd2, 1'b1, 32'h11A2_0000, 32'hFFFF_FFA2};
    tbl[7] = '{2'd3, 2'd1, 1'b1, 32'hDEAD_BEEF, 32'hDEAD_BEEF};

    agu_idle(); gnt = 0; rvalid = 0; rdata = 32'h0;
    rst_n = 0;
    repeat (3) @(posedge clk);
    #1 rst_n = 1;

    // Reset state
    @(negedge clk);
    check("rst_req", 32'(req), 0);
    check("rst_stall", 32'(stall), 0);
    check("rst_wbv", 32'(wbv), 0);
    check("rst_wbd", wbd, 0);
    check("rst_dest", 32'(wbdest), 0);
    check("rst_err", 32'(err), 0);
    next_cycle();

    // 1: store word granted immediately
    agu_req(1, 0, 4'hF, 2'd0, 0, 5'd0, 32'h100, 32'hCAFE_F00D); gnt = 1;
    @(negedge clk);
    check("t1_req", 32'(req), 1);
    check("t1_we", 32'(dwe), 1);
    check("t1_be", 32'(dbe), 32'hF);
    check("t1_addr", 32'(daddr), 32'h40);
    check("t1_wdata", dwdata, 32'hCAFE_F00D);
    check("t1_stall", 32'(stall), 0);
    next_cycle();
    agu_idle(); gnt = 0;
    @(negedge clk);
    check("t1_stall_after", 32'(stall), 0);
    check("t1_req_after", 32'(req), 0);
    next_cycle();

    // 2: signed byte load, rvalid two cycles after the grant
    agu_req(0, 1, 4'h8, 2'd2, 1, 5'd9, 32'h103, 32'h0); gnt = 1;
    @(negedge clk);
    check("t2_req", 32'(req), 1);
    check("t2_we", 32'(dwe), 0);
    next_cycle();
    agu_idle(); gnt = 0;
    @(negedge clk);
    check("t2_stall_wait", 32'(stall), 1);
    check("t2_req_wait", 32'(req), 0);
    next_cycle();
    rvalid = 1; rdata = 32'h8011_2233;
    @(negedge clk);
    check("t2_stall_rv", 32'(stall), 1);
    check("t2_wbv_rv", 32'(wbv), 0);
    next_cycle();
    rvalid = 0; rdata = 32'h0;
    @(negedge clk);
    check("t2_wbv", 32'(wbv), 1);
    check("t2_wbd", wbd, 32'hFFFF_FF80);
    check("t2_dest", 32'(wbdest), 9);
    check("t2_stall_rel", 32'(stall), 0);
    next_cycle();
    @(negedge clk);
    check("t2_wbv_pulse", 32'(wbv), 0);
    check("t2_wbd_hold", wbd, 32'hFFFF_FF80);
    next_cycle();

    // 3: unsigned half load, grant withheld three cycles; AGU inputs
    // scrambled while stalled to prove the held request is presented
    agu_req(0, 1, 4'hC, 2'd1, 0, 5'd3, 32'h0A2, 32'h0); gnt = 0;
    for (int c = 0; c < 4; c++) begin
      gnt = (c == 3);
      @(negedge clk);
      check("t3_req", 32'(req), 1);
      check("t3_addr", 32'(daddr), 32'h28);
      check("t3_we", 32'(dwe), 0);
      check("t3_stall", 32'(stall), 1);
      next_cycle();
      agu_req(1, 1, 4'hF, 2'd2, 1, 5'd30, 32'hFFFF_FFFC, 32'h5555_5555);
    end
    gnt = 0; rvalid = 1; rdata = 32'hBEEF_1234;
    @(negedge clk);
    check("t3_req_wait", 32'(req), 0);
    next_cycle();
    rvalid = 0; agu_idle();
    @(negedge clk);
    check("t3_wbv", 32'(wbv), 1);
    check("t3_wbd", wbd, 32'h0000_BEEF);
    check("t3_dest", 32'(wbdest), 3);
    next_cycle();

    // 4: zero byte-enable store suppressed; we&re issued as a write
    agu_req(1, 0, 4'h0, 2'd2, 0, 5'd0, 32'h200, 32'h1111_1111); gnt = 0;
    @(negedge clk);
    check("t4_req_be0", 32'(req), 0);
    check("t4_stall_be0", 32'(stall), 0);
    next_cycle();
    agu_req(1, 1, 4'h3, 2'd1, 0, 5'd4, 32'h204, 32'h2222_2222); gnt = 1;
    @(negedge clk);
    check("t4_req_both", 32'(req), 1);
    check("t4_we_both", 32'(dwe), 1);
    check("t4_be_both", 32'(dbe), 32'h3);
    check("t4_stall_both", 32'(stall), 0);
    next_cycle();
    agu_idle(); gnt = 0;
    @(negedge clk);
    check("t4_no_wait", 32'(stall), 0);
    next_cycle();

    // 6: load then store back to back
    agu_req(0, 1, 4'h2, 2'd2, 0, 5'd7, 32'h201, 32'h0); gnt = 1;
    @(negedge clk);
    check("t6_ld_stall", 32'(stall), 0);
    next_cycle();
    agu_idle(); gnt = 0; rvalid = 1; rdata = 32'h0000_AB00;
    @(negedge clk);
    check("t6_rv_stall", 32'(stall), 1);
    next_cycle();
    rvalid = 0; agu_req(1, 0, 4'hF, 2'd0, 0, 5'd0, 32'h300, 32'h1234_5678); gnt = 1;
    @(negedge clk);
    check("t6_st_req", 32'(req), 1);
    check("t6_st_we", 32'(dwe), 1);
    check("t6_st_addr", 32'(daddr), 32'hC0);
    check("t6_st_stall", 32'(stall), 0);
    check("t6_wbv", 32'(wbv), 1);
    check("t6_wbd", wbd, 32'h0000_00AB);
    check("t6_dest", 32'(wbdest), 7);
    next_cycle();
    agu_idle(); gnt = 0;
    @(negedge clk);
    check("t6_wbv_drop", 32'(wbv), 0);
    check("t6_req_drop", 32'(req), 0);
    next_cycle();

    // Alignment vectors
    for (int i = 0; i < 8; i++) begin
      agu_req(0, 1, 4'hF, tbl[i].op, tbl[i].sgn, 5'(i + 1), 32'h400 | 32'(tbl[i].off), 32'h0);
      gnt = 1;
      @(negedge clk);
      check("tbl_stall", 32'(stall), 0);
      next_cycle();
      agu_idle(); gnt = 0; rvalid = 1; rdata = tbl[i].rdata;
      next_cycle();
      rvalid = 0; rdata = 32'h0;
      seen = 0;
      for (int k = 0; k < 4 && !seen; k++) begin
        @(negedge clk);
        if (wbv) seen = 1;
        else next_cycle();
      end
      check("tbl_wbv", 32'(seen), 1);
      check("tbl_wbd", wbd, tbl[i].exp);
      check("tbl_dest", 32'(wbdest), 32'(i + 1));
      next_cycle();
    end

    // 5: reset while waiting for read data, then the stray rvalid
    agu_req(0, 1, 4'hF, 2'd0, 0, 5'd12, 32'h500, 32'h0); gnt = 1;
    next_cycle();
    agu_idle(); gnt = 0;
    @(negedge clk);
    check("t5_wait_stall", 32'(stall), 1);
    rst_n = 0;
    #1;
    check("t5_rst_stall", 32'(stall), 0);
    check("t5_rst_err", 32'(err), 0);
    next_cycle();
    rst_n = 1; rvalid = 1; rdata = 32'h7777_7777;
    next_cycle();
    rvalid = 0;
    @(negedge clk);
    check("t5_err", 32'(err), 1);
    check("t5_wbv", 32'(wbv), 0);
    check("t5_stall", 32'(stall), 0);
    next_cycle();

    // Randomized traffic against the reference model
    rst_n = 0;
    next_cycle();
    rst_n = 1;
    last_wbd = 32'h0; last_dest = 5'd0;
    for (int t = 0; t < 200; t++) begin
      int kind, gd, rd, opc, off;
      bit is_store, issue, s;
      logic [3:0]  b;
      logic [4:0]  d;
      logic [31:0] a, data, rw;
      kind = $urandom_range(0, 9);
      is_store = (kind >= 4);
      b = (kind == 9) ? 4'h0 : 4'($urandom_range(0, 15));
      opc = $urandom_range(0, 3);
      s = 1'($urandom_range(0, 1));
      d = 5'($urandom_range(0, 31));
      a = $urandom; data = $urandom;
      off = int'(a[1:0]);
      issue = is_store ? (b != 4'h0) : 1'b1;
      agu_req(is_store, (kind == 8) || !is_store, b, 2'(opc), s, d, a, data);
      gd = $urandom_range(0, 3);
      if (!issue) begin
        gnt = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("rnd_noreq", 32'(req), 0);
        check("rnd_nostall", 32'(stall), 0);
        next_cycle();
        continue;
      end
      for (int c = 0; c <= gd; c++) begin
        gnt = (c == gd);
        @(negedge clk);
        if (c == 0) begin
          check("rnd_wbv_idle", 32'(wbv), 0);
          check("rnd_wbd_hold", wbd, last_wbd);
        end
        check("rnd_req", 32'(req), 1);
        check("rnd_we", 32'(dwe), 32'(is_store));
        check("rnd_addr", 32'(daddr), a >> 2);
        if (is_store) begin
          check("rnd_be", 32'(dbe), 32'(b));
          check("rnd_wdata", dwdata, data);
        end
        check("rnd_stall", 32'(stall), 32'((c != 0) || (gd != 0)));
        next_cycle();
        agu_req(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)),
                2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)),
                $urandom, $urandom);
      end
      gnt = 0;
      if (!is_store) begin
        rd = $urandom_range(0, 2);
        rw = $urandom;
        for (int c = 0; c <= rd; c++) begin
          rvalid = (c == rd);
          rdata = (c == rd) ? rw : $urandom;
          @(negedge clk);
          check("rnd_wait_req", 32'(req), 0);
          check("rnd_wait_stall", 32'(stall), 1);
          next_cycle();
        end
        rvalid = 0; agu_idle();
        last_wbd = ref_align(opc, off, s, rw);
        last_dest = d;
        @(negedge clk);
        check("rnd_wbv", 32'(wbv), 1);
        check("rnd_wbd", wbd, last_wbd);
        check("rnd_dest", 32'(wbdest), 32'(last_dest));
        next_cycle();
      end
    end
    agu_idle();
    @(negedge clk);
    check("rnd_err_clear", 32'(err), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
